// File: rtl/fetch_state_regs_pkg.sv
// Shared encodings for the multicycle MIPS fetch/state register stage.
// The opcode constants are also used by the control unit.
package fetch_state_regs_pkg;

    typedef enum logic [1:0] {
        PC_SRC_ALU    = 2'b00,
        PC_SRC_ALUOUT = 2'b01,
        PC_SRC_JUMP   = 2'b10,
        PC_SRC_RSVD   = 2'b11
    } pc_src_e;

    localparam logic [5:0] RTYPE = 6'h00;
    localparam logic [5:0] LW    = 6'h23;
    localparam logic [5:0] SW    = 6'h2B;
    localparam logic [5:0] BEQ   = 6'h04;
    localparam logic [5:0] ADDI  = 6'h08;
    localparam logic [5:0] J     = 6'h02;

    // IR field bit positions
    localparam int OPCODE_MSB = 31;
    localparam int OPCODE_LSB = 26;
    localparam int RS_MSB     = 25;
    localparam int RS_LSB     = 21;
    localparam int RT_MSB     = 20;
    localparam int RT_LSB     = 16;
    localparam int RD_MSB     = 15;
    localparam int RD_LSB     = 11;
    localparam int IMM_MSB    = 15;
    localparam int IMM_LSB    = 0;
    localparam int FUNCT_MSB  = 5;
    localparam int FUNCT_LSB  = 0;
    localparam int JIDX_MSB   = 25;
    localparam int JIDX_LSB   = 0;
    localparam int IMM_W      = IMM_MSB - IMM_LSB + 1;
    localparam int REG_IDX_W  = 5;

endpackage

// File: rtl/fetch_state_regs_en_reg.sv
// Width/reset-value parameterised register with load enable and
// asynchronous active-low reset.
module en_reg #(
    parameter int                 WIDTH_P     = 32,
    parameter logic [WIDTH_P-1:0] RESET_VAL_P = '0
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               i_en,
    input  logic [WIDTH_P-1:0] i_d,
    output logic [WIDTH_P-1:0] o_q
);

    logic [WIDTH_P-1:0] q_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q_q <= RESET_VAL_P;
        end else if (i_en) begin
            q_q <= i_d;
        end
    end

    assign o_q = q_q;

endmodule

// File: rtl/fetch_state_regs.sv
// PC / IR / MDR / ALUOut state stage of the multicycle MIPS datapath,
// plus memory address mux, jump target, alignment flag and fetch counter.
module fetch_state_regs
    import fetch_state_regs_pkg::*;
#(
    parameter int                      DATA_WIDTH_P  = 32,
    parameter int                      ADDR_WIDTH_P  = 32,
    parameter logic [ADDR_WIDTH_P-1:0] RESET_PC_P    = 32'h0000_0000,
    parameter int                      OP_WIDTH_P    = 6,
    parameter int                      FUNCT_WIDTH_P = 6
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     i_enable_pc,
    input  logic                     i_branch,
    input  logic [1:0]               i_pc_next_sel,
    input  logic                     i_instr_wr_en,
    input  logic                     i_instr_data_addr_sel,
    input  logic [DATA_WIDTH_P-1:0]  i_alu_result,
    input  logic                     i_alu_zero,
    input  logic [DATA_WIDTH_P-1:0]  i_mem_rd_data,
    output logic [ADDR_WIDTH_P-1:0]  o_mem_addr,
    output logic [ADDR_WIDTH_P-1:0]  o_pc,
    output logic [OP_WIDTH_P-1:0]    o_opcode,
    output logic [FUNCT_WIDTH_P-1:0] o_function,
    output logic [REG_IDX_W-1:0]     o_rs,
    output logic [REG_IDX_W-1:0]     o_rt,
    output logic [REG_IDX_W-1:0]     o_rd,
    output logic [DATA_WIDTH_P-1:0]  o_imm_sext,
    output logic [DATA_WIDTH_P-1:0]  o_mdr,
    output logic [DATA_WIDTH_P-1:0]  o_alu_out,
    output logic                     o_pc_misaligned,
    output logic [31:0]              o_instret
);

    logic [ADDR_WIDTH_P-1:0] pc_q, pc_d;
    logic [ADDR_WIDTH_P-1:0] jump_tgt;
    logic [DATA_WIDTH_P-1:0] ir_q, mdr_q, alu_out_q;
    logic                    pc_en, pc_ld;
    logic                    misaligned_q, misaligned_d;
    logic [31:0]             instret_q, instret_d;

    assign pc_en    = i_enable_pc | (i_branch & i_alu_zero);
    assign jump_tgt = {pc_q[ADDR_WIDTH_P-1:28], ir_q[JIDX_MSB:JIDX_LSB], 2'b00};

    // pc_ld stays low for the reserved select so the PC simply holds.
    always_comb begin
        pc_d  = pc_q;
        pc_ld = 1'b0;
        if (pc_en) begin
            case (pc_src_e'(i_pc_next_sel))
                PC_SRC_ALU: begin
                    pc_d  = i_alu_result[ADDR_WIDTH_P-1:0];
                    pc_ld = 1'b1;
                end
                PC_SRC_ALUOUT: begin
                    pc_d  = alu_out_q[ADDR_WIDTH_P-1:0];
                    pc_ld = 1'b1;
                end
                PC_SRC_JUMP: begin
                    pc_d  = jump_tgt;
                    pc_ld = 1'b1;
                end
                default: begin
                    pc_d  = pc_q;
                    pc_ld = 1'b0;
                end
            endcase
        end
    end

    assign misaligned_d = misaligned_q | (pc_ld & (|pc_d[1:0]));
    assign instret_d    = i_instr_wr_en ? instret_q + 32'd1 : instret_q;

    en_reg #(.WIDTH_P(ADDR_WIDTH_P), .RESET_VAL_P(RESET_PC_P)) u_pc (
        .clk     (clk),
        .reset_n (reset_n),
        .i_en    (pc_ld),
        .i_d     (pc_d),
        .o_q     (pc_q)
    );

    en_reg #(.WIDTH_P(DATA_WIDTH_P), .RESET_VAL_P('0)) u_ir (
        .clk     (clk),
        .reset_n (reset_n),
        .i_en    (i_instr_wr_en),
        .i_d     (i_mem_rd_data),
        .o_q     (ir_q)
    );

    en_reg #(.WIDTH_P(DATA_WIDTH_P), .RESET_VAL_P('0)) u_mdr (
        .clk     (clk),
        .reset_n (reset_n),
        .i_en    (1'b1),
        .i_d     (i_mem_rd_data),
        .o_q     (mdr_q)
    );

    en_reg #(.WIDTH_P(DATA_WIDTH_P), .RESET_VAL_P('0)) u_alu_out (
        .clk     (clk),
        .reset_n (reset_n),
        .i_en    (1'b1),
        .i_d     (i_alu_result),
        .o_q     (alu_out_q)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            misaligned_q <= 1'b0;
            instret_q    <= '0;
        end else begin
            misaligned_q <= misaligned_d;
            instret_q    <= instret_d;
        end
    end

    assign o_mem_addr      = i_instr_data_addr_sel ? alu_out_q[ADDR_WIDTH_P-1:0] : pc_q;
    assign o_pc            = pc_q;
    assign o_opcode        = ir_q[OPCODE_MSB:OPCODE_LSB];
    assign o_function      = ir_q[FUNCT_MSB:FUNCT_LSB];
    assign o_rs            = ir_q[RS_MSB:RS_LSB];
    assign o_rt            = ir_q[RT_MSB:RT_LSB];
    assign o_rd            = ir_q[RD_MSB:RD_LSB];
    assign o_imm_sext      = {{(DATA_WIDTH_P-IMM_W){ir_q[IMM_MSB]}}, ir_q[IMM_MSB:IMM_LSB]};
    assign o_mdr           = mdr_q;
    assign o_alu_out       = alu_out_q;
    assign o_pc_misaligned = misaligned_q;
    assign o_instret       = instret_q;

endmodule
